conv_mem_responder: RTL and testbench

//  Memory/handshake responder at the far end of the CONV accelerator interface (the testbench-side model).

---
 rtl/conv_mem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// conv_mem_responder
//   Far-end memory/handshake responder for the CONV accelerator interface.
//   Holds the input image ROM (preloaded in LOAD) and the five layer banks
//   addressed through csel. A small FSM (LOAD -> READY -> RUN -> DONE) gates
//   which accesses are honoured. The FSM can only leave DONE through rst.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   img_we/waddr/wdata    image preload write port (honoured in LOAD only)
//   load_done             one-cycle pulse ending the preload
//   busy                  CONV busy level; starts and ends RUN
//   iaddr -> idata        image read, 1-cycle latency, in READY/RUN
//   crd/caddr_rd          layer read request -> cdata_rd (1-cycle latency)
//   cwr/caddr_wr/cdata_wr layer write request
//   csel                  bank select: 1 L0K0, 2 L0K1, 3 L1K0, 4 L1K1, 5 L2
//   ready, done           handshake status, registered
//   err_csel/addr/state   sticky error flags, cleared only by rst
module conv_mem_responder #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned IMG_D  = 4096,
  parameter int unsigned L0_D   = 4096,
  parameter int unsigned L1_D   = 1024,
  parameter int unsigned L2_D   = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_waddr,
  input  logic [DATA_W-1:0] img_wdata,
  input  logic              load_done,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic [2:0]        csel,
  output logic              ready,
  output logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] cdata_rd,
  output logic              done,
  output logic              err_csel,
  output logic              err_addr,
  output logic              err_state
);

  localparam int IMG_AW = $clog2(IMG_D);
  localparam int L0_AW  = $clog2(L0_D);
  localparam int L1_AW  = $clog2(L1_D);
  localparam int L2_AW  = $clog2(L2_D);

  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when addr indexes a real entry of a memory of the given depth.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return (32'(addr) < depth);
  endfunction

  state_t state_r, state_nxt_s;

  // Memories are deliberately not reset: contents survive rst so the image
  // does not need to be reloaded after a mid-run reset.
  logic [DATA_W-1:0] img_mem_r  [IMG_D];
  logic [DATA_W-1:0] l0k0_mem_r [L0_D];
  logic [DATA_W-1:0] l0k1_mem_r [L0_D];
  logic [DATA_W-1:0] l1k0_mem_r [L1_D];
  logic [DATA_W-1:0] l1k1_mem_r [L1_D];
  logic [DATA_W-1:0] l2_mem_r   [L2_D];

  logic              ready_r, done_r;
  logic [DATA_W-1:0] idata_r, cdata_r;
  logic              err_csel_r, err_addr_r, err_state_r;

  logic              in_load_s, in_run_s, img_rd_en_s;
  logic              csel_valid_s;
  int unsigned       bank_depth_s;
  logic              img_wr_ok_s, iaddr_ok_s, rd_ok_s, wr_ok_s;
  logic              rd_en_s, wr_en_s;
  logic [DATA_W-1:0] bank_rdata_s;
  logic              err_addr_set_s, err_csel_set_s, err_state_set_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; DONE is terminal until rst.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_done) state_nxt_s = ST_READY;
        else           state_nxt_s = ST_LOAD;
      end
      ST_READY: begin
        if (busy) state_nxt_s = ST_RUN;
        else      state_nxt_s = ST_READY;
      end
      ST_RUN: begin
        if (!busy) state_nxt_s = ST_DONE;
        else       state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Bank select decode: validity and depth of the addressed bank.
  always_comb begin
    csel_valid_s = 1'b1;
    bank_depth_s = 32'd0;
    case (csel)
      CSEL_L0K0, CSEL_L0K1: bank_depth_s = L0_D;
      CSEL_L1K0, CSEL_L1K1: bank_depth_s = L1_D;
      CSEL_L2:              bank_depth_s = L2_D;
      default: begin
        csel_valid_s = 1'b0;
        bank_depth_s = 32'd0;
      end
    endcase
  end

  // Access qualification and error-event detection.
  always_comb begin
    in_load_s    = (state_r == ST_LOAD);
    in_run_s     = (state_r == ST_RUN);
    img_rd_en_s  = (state_r == ST_READY) || (state_r == ST_RUN);
    img_wr_ok_s  = addr_in_range(img_waddr, IMG_D);
    iaddr_ok_s   = addr_in_range(iaddr, IMG_D);
    rd_ok_s      = addr_in_range(caddr_rd, bank_depth_s);
    wr_ok_s      = addr_in_range(caddr_wr, bank_depth_s);
    rd_en_s      = in_run_s && crd && csel_valid_s;
    wr_en_s      = in_run_s && cwr && csel_valid_s;
    err_addr_set_s  = (in_load_s && img_we && !img_wr_ok_s) ||
                      (img_rd_en_s && !iaddr_ok_s) ||
                      (rd_en_s && !rd_ok_s) ||
                      (wr_en_s && !wr_ok_s);
    // Strobes outside RUN are reported only as a state error.
    err_csel_set_s  = in_run_s && (crd || cwr) && !csel_valid_s;
    err_state_set_s = !in_run_s && (crd || cwr);
  end

  // Layer bank read mux. Narrow banks use the low address bits; the range
  // check above discards any aliased result.
  always_comb begin
    bank_rdata_s = {DATA_W{1'b0}};
    case (csel)
      CSEL_L0K0: bank_rdata_s = l0k0_mem_r[caddr_rd[L0_AW-1:0]];
      CSEL_L0K1: bank_rdata_s = l0k1_mem_r[caddr_rd[L0_AW-1:0]];
      CSEL_L1K0: bank_rdata_s = l1k0_mem_r[caddr_rd[L1_AW-1:0]];
      CSEL_L1K1: bank_rdata_s = l1k1_mem_r[caddr_rd[L1_AW-1:0]];
      CSEL_L2:   bank_rdata_s = l2_mem_r[caddr_rd[L2_AW-1:0]];
      default:   bank_rdata_s = {DATA_W{1'b0}};
    endcase
  end

  // Image preload write port.
  always_ff @(posedge clk) begin
    if (in_load_s && img_we && img_wr_ok_s) begin
      img_mem_r[img_waddr[IMG_AW-1:0]] <= img_wdata;
    end
  end

  // Layer bank write port. A same-cycle read sees the pre-write contents
  // because the read is sampled from the arrays before this update lands.
  always_ff @(posedge clk) begin
    if (wr_en_s && wr_ok_s) begin
      case (csel)
        CSEL_L0K0: l0k0_mem_r[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        CSEL_L0K1: l0k1_mem_r[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        CSEL_L1K0: l1k0_mem_r[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        CSEL_L1K1: l1k1_mem_r[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        CSEL_L2:   l2_mem_r[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default:   ;
      endcase
    end
  end

  // Registered outputs and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r     <= 1'b0;
      done_r      <= 1'b0;
      idata_r     <= {DATA_W{1'b0}};
      cdata_r     <= {DATA_W{1'b0}};
      err_csel_r  <= 1'b0;
      err_addr_r  <= 1'b0;
      err_state_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_READY);
      done_r  <= (state_nxt_s == ST_DONE);
      if (img_rd_en_s) begin
        idata_r <= iaddr_ok_s ? img_mem_r[iaddr[IMG_AW-1:0]] : {DATA_W{1'b0}};
      end
      if (rd_en_s) begin
        cdata_r <= rd_ok_s ? bank_rdata_s : {DATA_W{1'b0}};
      end
      err_csel_r  <= err_csel_r  | err_csel_set_s;
      err_addr_r  <= err_addr_r  | err_addr_set_s;
      err_state_r <= err_state_r | err_state_set_s;
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign idata     = idata_r;
  assign cdata_rd  = cdata_r;
  assign err_csel  = err_csel_r;
  assign err_addr  = err_addr_r;
  assign err_state = err_state_r;

endmodule

// File: tb/tb_conv_mem_responder.sv
// tb_conv_mem_responder
//   Directed scenarios plus randomized RUN traffic for conv_mem_responder.
//   A behavioural model (associative-array memories, phase counter, sticky
//   flags) predicts every output; one process compares on each falling edge.
module tb_conv_mem_responder;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int IMG_D  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              img_we = 1'b0;
  logic [ADDR_W-1:0] img_waddr = 12'd0;
  logic [DATA_W-1:0] img_wdata = 20'd0;
  logic              load_done = 1'b0;
  logic              busy = 1'b0;
  logic [ADDR_W-1:0] iaddr = 12'd0;
  logic              crd = 1'b0;
  logic [ADDR_W-1:0] caddr_rd = 12'd0;
  logic              cwr = 1'b0;
  logic [ADDR_W-1:0] caddr_wr = 12'd0;
  logic [DATA_W-1:0] cdata_wr = 20'd0;
  logic [2:0]        csel = 3'd1;
  logic              ready, done, err_csel, err_addr, err_state;
  logic [DATA_W-1:0] idata, cdata_rd;

  conv_mem_responder dut (
    .clk(clk), .rst(rst), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .load_done(load_done), .busy(busy), .iaddr(iaddr),
    .crd(crd), .caddr_rd(caddr_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel), .ready(ready), .idata(idata),
    .cdata_rd(cdata_rd), .done(done), .err_csel(err_csel),
    .err_addr(err_addr), .err_state(err_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 loading, 1 waiting for busy, 2 running, 3 finished
  int                m_phase;
  logic [DATA_W-1:0] img_m  [int];
  logic [DATA_W-1:0] bank_m [int];
  logic [DATA_W-1:0] idata_exp, cdata_exp;
  bit                idata_known, cdata_known;
  bit                e_addr, e_csel, e_state;

  initial begin : model_and_compare
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = 0; e_addr = 0; e_csel = 0; e_state = 0;
        idata_exp = 20'd0; cdata_exp = 20'd0; idata_known = 1; cdata_known = 1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idata", 32'(idata), 32'd0);
        chk("rst_cdata", 32'(cdata_rd), 32'd0);
        chk("rst_errs", {29'd0, err_csel, err_addr, err_state}, 32'd0);
      end else begin
        chk("ready", 32'(ready), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("err_csel", 32'(err_csel), 32'(e_csel));
        chk("err_addr", 32'(err_addr), 32'(e_addr));
        chk("err_state", 32'(err_state), 32'(e_state));
        if (idata_known) chk("idata", 32'(idata), 32'(idata_exp));
        if (cdata_known) chk("cdata_rd", 32'(cdata_rd), 32'(cdata_exp));
        // advance the model with the inputs the next rising edge will see
        if (m_phase == 0) begin
          if (img_we) begin
            if (int'(img_waddr) < IMG_D) img_m[int'(img_waddr)] = img_wdata;
            else e_addr = 1;
          end
          if (crd || cwr) e_state = 1;
          if (load_done) m_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
          if (int'(iaddr) >= IMG_D) begin
            idata_exp = 20'd0; idata_known = 1; e_addr = 1;
          end else if (img_m.exists(int'(iaddr))) begin
            idata_exp = img_m[int'(iaddr)]; idata_known = 1;
          end else begin
            idata_known = 0;
          end
          if (m_phase == 1) begin
            if (crd || cwr) e_state = 1;
            if (busy) m_phase = 2;
          end else begin
            if ((crd || cwr) && depth_of(csel) == 0) e_csel = 1;
            if ((crd || cwr) && depth_of(csel) != 0) begin
              if (crd) begin
                if (int'(caddr_rd) >= depth_of(csel)) begin
                  cdata_exp = 20'd0; cdata_known = 1; e_addr = 1;
                end else if (bank_m.exists(int'(csel) * 65536 + int'(caddr_rd))) begin
                  cdata_exp = bank_m[int'(csel) * 65536 + int'(caddr_rd)];
                  cdata_known = 1;
                end else begin
                  cdata_known = 0;
                end
              end
              if (cwr) begin
                if (int'(caddr_wr) >= depth_of(csel)) e_addr = 1;
                else bank_m[int'(csel) * 65536 + int'(caddr_wr)] = cdata_wr;
              end
            end
            if (!busy) m_phase = 3;
          end
        end else begin
          if (crd || cwr) e_state = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr(input int d, input bit wild);
    if (wild && d > 0 && $urandom_range(0, 3) == 0)
      return 12'(d - 2 + int'($urandom_range(0, 3)));
    return 12'($urandom_range(16, 31));
  endfunction

  task automatic rand_run(input int cycles, input bit wild);
    for (int i = 0; i < cycles; i++) begin
      logic [2:0] s;
      s = wild ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
      csel      = s;
      crd       = 1'($urandom_range(0, 1));
      cwr       = 1'($urandom_range(0, 1));
      caddr_rd  = pick_addr(depth_of(s), wild);
      caddr_wr  = pick_addr(depth_of(s), wild);
      cdata_wr  = 20'($urandom);
      iaddr     = ($urandom_range(0, 9) == 0) ? 12'd4095 : 12'($urandom_range(0, 63));
      load_done = ($urandom_range(0, 15) == 0);
      img_we    = ($urandom_range(0, 15) == 0);
      img_waddr = 12'($urandom_range(0, 63));
      img_wdata = 20'($urandom);
      busy      = 1'b1;
      step();
    end
    crd = 1'b0; cwr = 1'b0; load_done = 1'b0; img_we = 1'b0;
  endtask

  task automatic bank_wr(input logic [2:0] s, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    csel = s; cwr = 1'b1; caddr_wr = a; cdata_wr = d;
    step();
    cwr = 1'b0;
  endtask

  task automatic bank_rd(input logic [2:0] s, input logic [ADDR_W-1:0] a);
    csel = s; crd = 1'b1; caddr_rd = a;
    step();
    crd = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stimulus
    rst = 1'b1;
    repeat (3) step();
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_errs", {29'd0, err_csel, err_addr, err_state}, 32'd0);
    rst = 1'b0;

    // T1: preload image
    img_we = 1'b1;
    img_waddr = 12'd0;    img_wdata = 20'h0_1000; step();
    img_waddr = 12'd4095; img_wdata = 20'hF_F000; step();
    for (int a = 1; a < 64; a++) begin
      img_waddr = 12'(a); img_wdata = 20'($urandom); step();
    end
    img_we = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    chk("t1_ready_up", 32'(ready), 32'd1);
    iaddr = 12'd0;
    load_done = 1'b1; step(); load_done = 1'b0; step();
    chk("t1_ready_holds", 32'(ready), 32'd1);
    chk("t1_idata0", 32'(idata), 32'h0_1000);
    busy = 1'b1; iaddr = 12'd4095; step();
    chk("t1_ready_falls", 32'(ready), 32'd0);
    chk("t1_idata4095", 32'(idata), 32'hF_F000);

    // T2: write L0K0[5], L0K1[5] stays separate
    bank_wr(3'd2, 12'd5, 20'h0_0055);
    bank_wr(3'd1, 12'd5, 20'h1_2345);
    bank_rd(3'd1, 12'd5);
    chk("t2_l0k0_rd", 32'(cdata_rd), 32'h1_2345);
    bank_rd(3'd2, 12'd5);
    chk("t2_l0k1_rd", 32'(cdata_rd), 32'h0_0055);

    // T3: same-cycle read/write returns old data
    bank_wr(3'd3, 12'd10, 20'h0_0000);
    csel = 3'd3; crd = 1'b1; caddr_rd = 12'd10;
    cwr = 1'b1; caddr_wr = 12'd10; cdata_wr = 20'h0_00AA;
    step();
    crd = 1'b0; cwr = 1'b0;
    chk("t3_old", 32'(cdata_rd), 32'h0_0000);
    bank_rd(3'd3, 12'd10);
    chk("t3_new", 32'(cdata_rd), 32'h0_00AA);

    rand_run(800, 1'b0);

    // T4: out-of-range write and invalid csel
    bank_wr(3'd3, 12'd0, 20'h0_0011);
    chk("t4_err_addr_pre", 32'(err_addr), 32'd0);
    bank_wr(3'd3, 12'd1024, 20'h7_7777);
    chk("t4_err_addr", 32'(err_addr), 32'd1);
    bank_rd(3'd3, 12'd0);
    chk("t4_dropped", 32'(cdata_rd), 32'h0_0011);
    chk("t4_err_csel_pre", 32'(err_csel), 32'd0);
    bank_rd(3'd7, 12'd0);
    chk("t4_csel_hold", 32'(cdata_rd), 32'h0_0011);
    chk("t4_err_csel", 32'(err_csel), 32'd1);

    rand_run(800, 1'b1);

    // T5: busy falls -> DONE; later strobe is a state error
    bank_rd(3'd3, 12'd10);
    chk("t5_pre_rd", 32'(cdata_rd), 32'h0_00AA);
    chk("t5_err_state_pre", 32'(err_state), 32'd0);
    busy = 1'b0; step();
    chk("t5_done", 32'(done), 32'd1);
    bank_rd(3'd1, 12'd5);
    chk("t5_err_state", 32'(err_state), 32'd1);
    chk("t5_cdata_hold", 32'(cdata_rd), 32'h0_00AA);
    busy = 1'b1; step();
    chk("t5_done_sticky", 32'(done), 32'd1);

    // T6: reset mid-RUN, contents persist
    busy = 1'b0; rst = 1'b1; step(); step(); rst = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    busy = 1'b1; step();
    bank_rd(3'd2, 12'd5);
    chk("t6_run_rd", 32'(cdata_rd), 32'h0_0055);
    #2; rst = 1'b1; #1;
    chk("t6_async_ready", 32'(ready), 32'd0);
    chk("t6_async_done", 32'(done), 32'd0);
    chk("t6_async_errs", {29'd0, err_csel, err_addr, err_state}, 32'd0);
    chk("t6_async_cdata", 32'(cdata_rd), 32'd0);
    chk("t6_async_idata", 32'(idata), 32'd0);
    step(); rst = 1'b0; busy = 1'b0;
    step();
    chk("t6_no_ready_wo_load_done", 32'(ready), 32'd0);
    load_done = 1'b1; step(); load_done = 1'b0;
    busy = 1'b1; step();
    bank_rd(3'd1, 12'd5);
    chk("t6_persist", 32'(cdata_rd), 32'h1_2345);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
